// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per cycle on operand magnitudes,
// followed by a sign-fix cycle; divide-by-zero short-cuts through a single ZERO cycle.
module div_seq #(
   parameter int WIDTH     = 8,
   parameter int SIGNED_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   output logic             busy,
   output logic             data_ok,
   output logic             div_zero,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CALC = 3'd1,
      S_FIX  = 3'd2,
      S_ZERO = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CW-1:0]    r_count;
   logic             r_sx;
   logic             r_sy;
   logic [WIDTH-1:0] r_ax;
   logic [WIDTH-1:0] r_ay;
   logic [WIDTH-1:0] r_p;

   logic             w_sgn;
   logic             w_sx;
   logic             w_sy;
   logic [WIDTH-1:0] w_ax;
   logic [WIDTH-1:0] w_ay;
   logic             w_yzero;
   logic [WIDTH:0]   w_p_shift;
   logic             w_ge;
   logic [WIDTH-1:0] w_sub;
   logic             w_last;
   logic             w_accept;
   logic             w_calc;
   logic             w_fix;
   logic             w_zero;

   assign w_sgn     = (SIGNED_EN != 0) && is_signed;
   assign w_sx      = w_sgn & X[WIDTH-1];
   assign w_sy      = w_sgn & Y[WIDTH-1];
   // Two's-complement negate; the most-negative value maps onto itself, which is its magnitude.
   assign w_ax      = w_sx ? -X : X;
   assign w_ay      = w_sy ? -Y : Y;
   assign w_yzero   = (Y == {WIDTH{1'b0}});
   // r_ax shifts dividend bits out at the top and collects quotient bits at the bottom.
   assign w_p_shift = {r_p, r_ax[WIDTH-1]};
   assign w_ge      = (w_p_shift >= {1'b0, r_ay});
   assign w_sub     = w_p_shift[WIDTH-1:0] - r_ay;
   assign w_last    = (r_count == CW'(WIDTH - 1));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_next = w_yzero ? S_ZERO : S_CALC;
            end else begin
               w_next = r_state;
            end
         end
         S_CALC: begin
            if (w_last) begin
               w_next = S_FIX;
            end else begin
               w_next = S_CALC;
            end
         end
         S_FIX:   w_next = S_DONE;
         S_ZERO:  w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   // State-decoded datapath controls
   always_comb begin
      w_accept = 1'b0;
      w_calc   = 1'b0;
      w_fix    = 1'b0;
      w_zero   = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: w_accept = start;
         S_CALC:         w_calc   = 1'b1;
         S_FIX:          w_fix    = 1'b1;
         S_ZERO:         w_zero   = 1'b1;
         default:        w_accept = 1'b0;
      endcase
   end

   // Operand capture, iteration, and registered result/status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count  <= {CW{1'b0}};
         r_sx     <= 1'b0;
         r_sy     <= 1'b0;
         r_ax     <= {WIDTH{1'b0}};
         r_ay     <= {WIDTH{1'b0}};
         r_p      <= {WIDTH{1'b0}};
         busy     <= 1'b0;
         data_ok  <= 1'b0;
         div_zero <= 1'b0;
         Q        <= {WIDTH{1'b0}};
         R        <= {WIDTH{1'b0}};
      end else if (w_accept) begin
         r_count  <= {CW{1'b0}};
         r_sx     <= w_sx;
         r_sy     <= w_sy;
         // A zero divisor reports the raw dividend as remainder, so keep it unmodified.
         r_ax     <= w_yzero ? X : w_ax;
         r_ay     <= w_ay;
         r_p      <= {WIDTH{1'b0}};
         busy     <= 1'b1;
         data_ok  <= 1'b0;
         div_zero <= 1'b0;
      end else if (w_calc) begin
         r_ax    <= {r_ax[WIDTH-2:0], w_ge};
         r_p     <= w_ge ? w_sub : w_p_shift[WIDTH-1:0];
         r_count <= w_last ? {CW{1'b0}} : r_count + CW'(1);
      end else if (w_fix) begin
         Q       <= (r_sx ^ r_sy) ? -r_ax : r_ax;
         R       <= r_sx ? -r_p : r_p;
         busy    <= 1'b0;
         data_ok <= 1'b1;
      end else if (w_zero) begin
         Q        <= {WIDTH{1'b1}};
         R        <= r_ax;
         div_zero <= 1'b1;
         busy     <= 1'b0;
         data_ok  <= 1'b1;
      end else begin
         busy <= busy;
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: an arithmetic reference model checked against two instances
// (8-bit signed-capable, 16-bit unsigned-only) every cycle, plus literal expectations.
module tb_div_seq;

   localparam int SE0 = 1;
   localparam int SE1 = 0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tst [2];
   logic        tsg [2];
   logic [31:0] tx  [2];
   logic [31:0] ty  [2];

   logic        busy8, ok8, dz8;
   logic [7:0]  q8, r8;
   logic        busy16, ok16, dz16;
   logic [15:0] q16, r16;

   // driver-provided literal expectations, latched by the model at accept
   logic        lit_en [2];
   logic [31:0] lit_q  [2];
   logic [31:0] lit_r  [2];
   logic        lit_dz [2];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   div_seq #(.WIDTH(8), .SIGNED_EN(SE0)) u_d8 (
      .clk(clk), .rst(rst), .start(tst[0]), .is_signed(tsg[0]),
      .X(tx[0][7:0]), .Y(ty[0][7:0]),
      .busy(busy8), .data_ok(ok8), .div_zero(dz8), .Q(q8), .R(r8)
   );

   div_seq #(.WIDTH(16), .SIGNED_EN(SE1)) u_d16 (
      .clk(clk), .rst(rst), .start(tst[1]), .is_signed(tsg[1]),
      .X(tx[1][15:0]), .Y(ty[1][15:0]),
      .busy(busy16), .data_ok(ok16), .div_zero(dz16), .Q(q16), .R(r16)
   );

   // reference arithmetic: truncating signed division via longint
   function automatic void mdl(input int w, input bit sg, input logic [31:0] x,
                               input logic [31:0] y, output logic [31:0] q,
                               output logic [31:0] r, output bit dz);
      longint xi, yi, mask;
      mask = (longint'(1) << w) - 1;
      xi   = longint'({32'd0, x}) & mask;
      yi   = longint'({32'd0, y}) & mask;
      dz   = (yi == 0);
      if (dz) begin
         q = 32'(mask);
         r = 32'(xi);
      end else begin
         if (sg && xi[w-1]) xi = xi - (longint'(1) << w);
         if (sg && yi[w-1]) yi = yi - (longint'(1) << w);
         q = 32'((xi / yi) & mask);
         r = 32'((xi % yi) & mask);
      end
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   bit          m_busy [2], m_ok [2], m_dz [2], m_known [2], m_fresh [2], m_lit [2];
   bit          m_pdz [2];
   logic [31:0] m_q [2], m_r [2], m_pq [2], m_pr [2], m_lq [2], m_lr [2];
   bit          m_ldz [2];
   int          m_edges [2], m_lat [2];

   // model step on each rising edge, then compare every DUT output 1 time unit later
   always begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         m_fresh[k] = 1'b0;
         if (rst) begin
            m_busy[k] = 1'b0; m_ok[k] = 1'b0; m_dz[k] = 1'b0;
            m_q[k] = 32'd0; m_r[k] = 32'd0; m_known[k] = 1'b1;
         end else if (m_busy[k]) begin
            m_edges[k]++;
            if (m_edges[k] == m_lat[k]) begin
               m_busy[k] = 1'b0; m_ok[k] = 1'b1; m_known[k] = 1'b1; m_fresh[k] = 1'b1;
               m_q[k] = m_pq[k]; m_r[k] = m_pr[k]; m_dz[k] = m_pdz[k];
            end
         end else if (tst[k]) begin
            mdl((k == 0) ? 8 : 16, tsg[k] && (((k == 0) ? SE0 : SE1) != 0),
                tx[k], ty[k], m_pq[k], m_pr[k], m_pdz[k]);
            m_lat[k]   = m_pdz[k] ? 2 : ((k == 0) ? 10 : 18);
            m_edges[k] = 1;
            m_busy[k] = 1'b1; m_ok[k] = 1'b0; m_dz[k] = 1'b0; m_known[k] = 1'b0;
            m_lit[k] = lit_en[k]; m_lq[k] = lit_q[k]; m_lr[k] = lit_r[k]; m_ldz[k] = lit_dz[k];
         end
      end
      #1;
      chk("busy8",    {31'd0, busy8},  {31'd0, m_busy[0]});
      chk("data_ok8", {31'd0, ok8},    {31'd0, m_ok[0]});
      chk("div_zero8",{31'd0, dz8},    {31'd0, m_dz[0]});
      if (m_known[0]) begin
         chk("Q8", {24'd0, q8}, m_q[0]);
         chk("R8", {24'd0, r8}, m_r[0]);
      end
      chk("busy16",    {31'd0, busy16}, {31'd0, m_busy[1]});
      chk("data_ok16", {31'd0, ok16},   {31'd0, m_ok[1]});
      chk("div_zero16",{31'd0, dz16},   {31'd0, m_dz[1]});
      if (m_known[1]) begin
         chk("Q16", {16'd0, q16}, m_q[1]);
         chk("R16", {16'd0, r16}, m_r[1]);
      end
      for (int k = 0; k < 2; k++) begin
         if (m_fresh[k] && m_lit[k]) begin
            chk($sformatf("lit_Q%0d", k),  m_q[k], m_lq[k]);
            chk($sformatf("lit_R%0d", k),  m_r[k], m_lr[k]);
            chk($sformatf("lit_dz%0d", k), {31'd0, m_dz[k]}, {31'd0, m_ldz[k]});
         end
      end
   end

   // one operation with a single-cycle start; returns on the cycle data_ok rises
   task automatic op(input int k, input logic [31:0] x, input logic [31:0] y, input logic sg,
                     input logic [31:0] lq, input logic [31:0] lr, input logic ldz);
      int lat;
      lat = ((k == 0) ? (y[7:0] == 8'd0) : (y[15:0] == 16'd0)) ? 2 : ((k == 0) ? 10 : 18);
      tx[k] = x; ty[k] = y; tsg[k] = sg;
      lit_en[k] = 1'b1; lit_q[k] = lq; lit_r[k] = lr; lit_dz[k] = ldz;
      tst[k] = 1'b1;
      @(negedge clk);
      tst[k] = 1'b0;
      tx[k] = $urandom; ty[k] = $urandom; tsg[k] = 1'($urandom);
      repeat (lat - 1) @(negedge clk);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         tst[k] = 1'b0; tsg[k] = 1'b0; tx[k] = 32'd0; ty[k] = 32'd0;
         lit_en[k] = 1'b0; lit_q[k] = 32'd0; lit_r[k] = 32'd0; lit_dz[k] = 1'b0;
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      op(0, 32'd22,   32'd3,   1'b0, 32'h07, 32'h01, 1'b0);
      op(0, 32'hF9,   32'h02,  1'b1, 32'hFD, 32'hFF, 1'b0);
      op(0, 32'h07,   32'hFE,  1'b1, 32'hFD, 32'h01, 1'b0);
      op(0, 32'h5A,   32'h00,  1'b0, 32'hFF, 32'h5A, 1'b1);
      op(0, 32'd9,    32'd3,   1'b0, 32'h03, 32'h00, 1'b0);
      op(0, 32'h80,   32'hFF,  1'b1, 32'h80, 32'h00, 1'b0);
      op(0, 32'd255,  32'd1,   1'b0, 32'hFF, 32'h00, 1'b0);
      op(0, 32'h80,   32'h00,  1'b1, 32'hFF, 32'h80, 1'b1);
      op(0, 32'h81,   32'h07,  1'b1, 32'hEE, 32'hFF, 1'b0);
      repeat (3) @(negedge clk);

      // start held through CALC with operands wandering: only 50/6 may count
      tx[0] = 32'd50; ty[0] = 32'd6; tsg[0] = 1'b0;
      lit_en[0] = 1'b1; lit_q[0] = 32'd8; lit_r[0] = 32'd2; lit_dz[0] = 1'b0;
      tst[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tx[0] = $urandom; ty[0] = $urandom; tsg[0] = 1'($urandom);
      end
      tst[0] = 1'b0;
      repeat (6) @(negedge clk);

      // reset pulsed mid-CALC: the aborted 200/9 must never report
      tx[0] = 32'd200; ty[0] = 32'd9; tsg[0] = 1'b0; lit_en[0] = 1'b0;
      tst[0] = 1'b1;
      @(negedge clk);
      tst[0] = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      op(0, 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);

      op(1, 32'hFFFF, 32'h0010, 1'b1, 32'h0FFF, 32'h000F, 1'b0);
      op(1, 32'h1234, 32'h0000, 1'b1, 32'hFFFF, 32'h1234, 1'b1);
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
